// File: rtl/plot_framebuffer.sv
// plot_framebuffer: receiving end of the drawing engines' plot interface.
// It range-checks single-pixel plots, stores them in an on-chip colour
// framebuffer, has a synchronous read port for scan-out or inspection,
// and a hardware clear-screen sequencer that fills every pixel.
module plot_framebuffer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_x,
  input  logic [6:0] vga_y,
  input  logic [2:0] vga_colour,
  input  logic       vga_plot,
  input  logic       clear_start,
  input  logic [2:0] clear_colour,
  output logic       busy,
  output logic       clear_done,
  output logic       plot_dropped,
  input  logic       rd_en,
  input  logic [7:0] rd_x,
  input  logic [6:0] rd_y,
  output logic [2:0] rd_colour,
  output logic       rd_valid
);

  localparam int          NPIX   = SCREEN_W * SCREEN_H;
  localparam logic [14:0] W15    = 15'(SCREEN_W);
  localparam logic [8:0]  X_LIM  = 9'(SCREEN_W);
  localparam logic [7:0]  Y_LIM  = 8'(SCREEN_H);
  localparam logic [7:0]  X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0]  Y_LAST = 7'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Linear pixel address, computed at full 15-bit width so the
  // y*W product never truncates.
  function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    return ({8'd0, y} * W15) + {7'd0, x};
  endfunction

  // Sequencer and flag state
  state_t     state_reg, state_next;
  logic [7:0] cnt_x_reg, cnt_x_next;
  logic [6:0] cnt_y_reg, cnt_y_next;
  logic [2:0] fill_colour_reg, fill_colour_next;
  logic       plot_dropped_reg, plot_dropped_next;

  // Write port of the framebuffer, shared by the plot path and the clear
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [2:0]  wr_data;

  // Read port registers
  logic [2:0]  rd_colour_reg;
  logic        rd_valid_reg;

  logic        plot_in_range;
  logic        rd_in_range;
  logic [14:0] plot_addr;
  logic [14:0] rd_addr;

  // Framebuffer storage; contents are deliberately not reset
  logic [2:0] mem [0:NPIX-1];

  assign plot_in_range = ({1'b0, vga_x} < X_LIM) && ({1'b0, vga_y} < Y_LIM);
  assign rd_in_range   = ({1'b0, rd_x} < X_LIM) && ({1'b0, rd_y} < Y_LIM);
  assign plot_addr     = pix_addr(vga_x, vga_y);
  assign rd_addr       = pix_addr(rd_x, rd_y);

  // State register, clear counters, latched fill colour and sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      cnt_x_reg        <= 8'd0;
      cnt_y_reg        <= 7'd0;
      fill_colour_reg  <= 3'd0;
      plot_dropped_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_x_reg        <= cnt_x_next;
      cnt_y_reg        <= cnt_y_next;
      fill_colour_reg  <= fill_colour_next;
      plot_dropped_reg <= plot_dropped_next;
    end
  end

  // Next-state logic and write-port arbitration: the clear owns the write
  // port while active, otherwise in-range plots write directly.
  always_comb begin
    state_next        = state_reg;
    cnt_x_next        = cnt_x_reg;
    cnt_y_next        = cnt_y_reg;
    fill_colour_next  = fill_colour_reg;
    plot_dropped_next = plot_dropped_reg;
    wr_en             = 1'b0;
    wr_addr           = plot_addr;
    wr_data           = vga_colour;

    case (state_reg)
      ST_IDLE: begin
        // A plot on the same edge as clear_start still lands; the clear
        // overwrites it later.
        wr_en = vga_plot && plot_in_range;
        if (clear_start) begin
          state_next        = ST_CLEAR;
          cnt_x_next        = 8'd0;
          cnt_y_next        = 7'd0;
          fill_colour_next  = clear_colour;
          plot_dropped_next = 1'b0;
        end
      end

      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = pix_addr(cnt_x_reg, cnt_y_reg);
        wr_data = fill_colour_reg;
        if (vga_plot) begin
          plot_dropped_next = 1'b1;
        end
        if (cnt_x_reg == X_LAST) begin
          cnt_x_next = 8'd0;
          if (cnt_y_reg == Y_LAST) begin
            cnt_y_next = 7'd0;
            state_next = ST_DONE;
          end else begin
            cnt_y_next = cnt_y_reg + 7'd1;
          end
        end else begin
          cnt_x_next = cnt_x_reg + 8'd1;
        end
      end

      ST_DONE: begin
        // Plots are accepted again; clear_start is ignored here.
        wr_en      = vga_plot && plot_in_range;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Framebuffer write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port: old data on a same-address write, zero out of
  // range, and the data register holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_reg  <= 1'b0;
      rd_colour_reg <= 3'd0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) begin
        rd_colour_reg <= rd_in_range ? mem[rd_addr] : 3'd0;
      end
    end
  end

  assign busy         = (state_reg == ST_CLEAR);
  assign clear_done   = (state_reg == ST_DONE);
  assign plot_dropped = plot_dropped_reg;
  assign rd_colour    = rd_colour_reg;
  assign rd_valid     = rd_valid_reg;

endmodule
